turf_fragment_reassembler: RTL and testbench
============================================

# turf_fragment_reassembler

Receive-side counterpart of the TURF fragment generator. It accepts a header stream and a fragmented payload stream, one 16-bit header per fragment, and rebuilds the original event. It emits the event bytes on a 64-bit data stream with `tlast` at the end of the event, then one 32-bit control word {addr, length}. This restores the event-control/event-data interface that feeds the fragment generator. Sequence and length violations are flagged and handled.

## Interface
- `aclk` – 1 – clock
- `areset` – in – 1 – reset, asynchronous, active-high
- `nfragment_count_i` – in – 10 – payload beats per full fragment minus 1 (17 → 18 beats = 144 B); static while events are open
- `s_hdr_tdata/tvalid/tready` – in/in/out – 16/1/1 – header: [11:0] event addr, [12] first, [13] last, [15:14] reserved (ignored)
- `s_payload_tdata/tkeep/tlast/tvalid/tready` – in/in/in/in/out – 64/8/1/1/1 – fragment payload; `tlast` ends fragment; `tkeep` contiguous from bit 0
- `m_data_tdata/tkeep/tlast/tvalid/tready` – out/out/out/out/in – 64/8/1/1/1 – reassembled event; `tlast` on final beat of event
- `m_ctrl_tdata/tvalid/tready` – out/out/in – 32/1/1 – [31:20] addr, [19:0] byte length
- `err_o` – out – 2 – one-cycle pulses: [0] sequence error, [1] fragment length error

## Operation
- States: IDLE, PAYLOAD, DROP, CTRL. Event-open flag `open`, latched `addr`, 20-bit `len`, 10-bit `beat`.
- IDLE: `s_hdr_tready`=1. On accepted header:
  - first=1 and !open → latch addr, len=0, open=1 → PAYLOAD.
  - first=0, open, addr match → PAYLOAD.
  - otherwise (first=0 while !open, first=1 while open, or addr mismatch) → err[0], DROP; open state unchanged.
- Per fragment: latch hdr last bit, beat=0.
- PAYLOAD: each accepted beat is forwarded to the output register; len += popcount(tkeep), saturating at 0xFFFFF; beat++.
  - `m_data_tlast` = s `tlast` AND hdr last.
  - On `tlast`:
    - If a non-last fragment's beat ≠ nfragment_count_i → err[1]; data is still forwarded.
    - If hdr last → CTRL.
    - Otherwise → IDLE.
  - If beat = nfragment_count_i and no `tlast`: forward the beat as final with `m_data_tlast` = hdr last, raise err[1], → DROP. From DROP, return to CTRL if hdr last, else IDLE.
- DROP: `s_payload_tready`=1, beats discarded, leave on `tlast`.
- CTRL: `m_ctrl_tvalid`=1 with {addr, len}. On handshake: open=0 → IDLE.
- `s_hdr_tready`=0 outside IDLE. `s_payload_tready`=0 in IDLE/CTRL.

## Timing
- Reset values:
  - All `tvalid` = 0.
  - `m_data_tdata`/`tkeep`/`tlast` = 0.
  - `m_ctrl_tdata` = 0.
  - `err_o` = 0.
  - state IDLE, open=0, len=0.
- Reset mid-event discards all partial state; no `tlast` or ctrl word is emitted for the aborted event.
- Data path: full-throughput single register slice, latency 1 cycle.
  - `s_payload_tready` = (state==PAYLOAD) && (!m_data_tvalid || m_data_tready).
  - 1 beat/cycle sustained.
- Header accepted in IDLE takes 1 cycle before payload is accepted (PAYLOAD entered the next cycle).
- CTRL is entered the cycle after the final beat is accepted. `m_ctrl_tvalid` can be high while that final beat is still held in the data register. Consumers must not assume the final data beat was transferred first.
- `m_ctrl_tvalid` is held with stable data until `m_ctrl_tready`.
- A new header is accepted no earlier than the cycle after the ctrl handshake.
- `err_o` pulses register in the cycle after the offending transfer.

## Structure
- Shared package `turf_frag_pkg`:
  - header bit positions (ADDR, FIRST, LAST)
  - ctrl field widths and packing function
  - state enum
  - The fragment generator is to import the same package.
- One sub-module: `turf_axis_reg_slice` (parameterized width, full-throughput register slice) for the data output.

## Test plan
- nfragment_count_i=17, addr 0x000, 1000 random bytes in 7 fragments (6×18 beats + 1×17 beats, first/last flags correct) → 125 data beats, identical bytes, `tlast` only on beat 125, then ctrl 0x000003E8; err_o=0.
- addr 0xABC, single first+last fragment, 1 beat, tkeep 0x1F → one data beat, tkeep 0x1F with `tlast`, ctrl 0xABC00005.
- Fragment with first=0 while idle (addr 0x123, 18 beats) → err[0] pulse, 18 beats discarded, no data/ctrl out; following valid event reassembles correctly.
- Middle fragment with 20 beats → 18 forwarded, err[1], 2 dropped; event completes with ctrl length = bytes forwarded.
- Random `m_data_tready`/`m_ctrl_tready` backpressure (50%) on the 1000-byte event → byte-exact output, no loss or duplication, ctrl stable while waiting.
- `areset` pulse after 3 fragments → all valids 0 the same cycle; next full event outputs correct ctrl with len counted from 0.

Source files
------------

// File: rtl/turf_fragment_reassembler_pkg.sv
// Shared TURF fragment definitions: header bit positions, control word packing and FSM states.
// The fragment generator and the reassembler both import this package.
package turf_frag_pkg;

  localparam int HDR_W        = 16;
  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_ADDR_W   = 12;
  localparam int HDR_FIRST    = 12;
  localparam int HDR_LAST     = 13;

  localparam int CTRL_ADDR_W = 12;
  localparam int CTRL_LEN_W  = 20;
  localparam int CTRL_W      = CTRL_ADDR_W + CTRL_LEN_W;
  localparam int BEAT_W      = 10;

  localparam logic [CTRL_LEN_W-1:0] LEN_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2,
    ST_CTRL    = 2'd3
  } state_t;

  function automatic logic [CTRL_W-1:0] pack_ctrl(input logic [CTRL_ADDR_W-1:0] addr,
                                                  input logic [CTRL_LEN_W-1:0]  len);
    return {addr, len};
  endfunction

  function automatic logic [3:0] keep_bytes(input logic [7:0] keep);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, keep[i]};
    return n;
  endfunction

endpackage

// File: rtl/turf_fragment_reassembler_if.sv
// Stream bundle of the reassembler: header and payload in, event data and control word out.
// Every stream transfers on a cycle where tvalid and tready are both high at the rising clock edge.
interface turf_fragment_reassembler_if;

  logic [15:0] s_hdr_tdata;
  logic        s_hdr_tvalid;
  logic        s_hdr_tready;

  logic [63:0] s_payload_tdata;
  logic [7:0]  s_payload_tkeep;
  logic        s_payload_tlast;
  logic        s_payload_tvalid;
  logic        s_payload_tready;

  logic [63:0] m_data_tdata;
  logic [7:0]  m_data_tkeep;
  logic        m_data_tlast;
  logic        m_data_tvalid;
  logic        m_data_tready;

  logic [31:0] m_ctrl_tdata;
  logic        m_ctrl_tvalid;
  logic        m_ctrl_tready;

  modport slave (
    input  s_hdr_tdata, s_hdr_tvalid,
    output s_hdr_tready,
    input  s_payload_tdata, s_payload_tkeep, s_payload_tlast, s_payload_tvalid,
    output s_payload_tready,
    output m_data_tdata, m_data_tkeep, m_data_tlast, m_data_tvalid,
    input  m_data_tready,
    output m_ctrl_tdata, m_ctrl_tvalid,
    input  m_ctrl_tready
  );

  modport master (
    output s_hdr_tdata, s_hdr_tvalid,
    input  s_hdr_tready,
    output s_payload_tdata, s_payload_tkeep, s_payload_tlast, s_payload_tvalid,
    input  s_payload_tready,
    input  m_data_tdata, m_data_tkeep, m_data_tlast, m_data_tvalid,
    output m_data_tready,
    input  m_ctrl_tdata, m_ctrl_tvalid,
    output m_ctrl_tready
  );

endinterface

// File: rtl/turf_fragment_reassembler_reg_slice.sv
// Full-throughput single-register stream slice: accepts a new word whenever empty or draining.
module turf_axis_reg_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_s_data,
  input  logic         i_s_valid,
  output logic         o_s_ready,
  output logic [W-1:0] o_m_data,
  output logic         o_m_valid,
  input  logic         i_m_ready
);

  logic         r_valid;
  logic [W-1:0] r_data;

  assign o_s_ready = !r_valid || i_m_ready;
  assign o_m_valid = r_valid;
  assign o_m_data  = r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_s_valid && o_s_ready) begin
      r_valid <= 1'b1;
      r_data  <= i_s_data;
    end else if (i_m_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/turf_fragment_reassembler.sv
// Rebuilds a TURF event from header-tagged payload fragments and emits the event bytes
// followed by one {addr, length} control word; sequence and length violations pulse err_o.
module turf_fragment_reassembler
  import turf_frag_pkg::*;
(
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [BEAT_W-1:0]         nfragment_count_i,
  turf_fragment_reassembler_if.slave bus,
  output logic [1:0]                err_o,
  output logic [1:0]                dbg_state_o
);

  localparam int SLICE_W = 64 + 8 + 1;

  state_t                 r_state;
  state_t                 w_next;
  logic                   r_open;
  logic                   r_hdr_last;
  logic                   r_drop_to_ctrl;
  logic [CTRL_ADDR_W-1:0] r_addr;
  logic [CTRL_LEN_W-1:0]  r_len;
  logic [BEAT_W-1:0]      r_beat;
  logic [1:0]             r_err;

  logic                   w_hdr_first;
  logic                   w_hdr_last;
  logic [HDR_ADDR_W-1:0]  w_hdr_addr;
  logic                   w_hdr_ok;
  logic                   w_hdr_acc;
  logic                   w_slice_ready;
  logic                   w_fwd;
  logic                   w_beat_full;
  logic                   w_out_last;
  logic                   w_overflow;
  logic                   w_short;
  logic                   w_hdr_tready;
  logic                   w_pay_tready;
  logic                   w_ctrl_tvalid;
  logic [CTRL_LEN_W:0]    w_len_sum;
  logic [CTRL_LEN_W-1:0]  w_len_next;
  logic [SLICE_W-1:0]     w_slice_out;

  assign w_hdr_first = bus.s_hdr_tdata[HDR_FIRST];
  assign w_hdr_last  = bus.s_hdr_tdata[HDR_LAST];
  assign w_hdr_addr  = bus.s_hdr_tdata[HDR_ADDR_LSB +: HDR_ADDR_W];
  assign w_hdr_ok    = (w_hdr_first && !r_open) ||
                       (!w_hdr_first && r_open && (w_hdr_addr == r_addr));
  assign w_hdr_acc   = bus.s_hdr_tvalid && (r_state == ST_IDLE);

  assign w_fwd       = bus.s_payload_tvalid && (r_state == ST_PAYLOAD) && w_slice_ready;
  assign w_beat_full = (r_beat == nfragment_count_i);
  // A full-length fragment without tlast is cut here, so its last forwarded beat closes it.
  assign w_out_last  = r_hdr_last && (bus.s_payload_tlast || w_beat_full);
  assign w_overflow  = w_fwd && w_beat_full && !bus.s_payload_tlast;
  assign w_short     = w_fwd && bus.s_payload_tlast && !r_hdr_last && !w_beat_full;

  assign w_len_sum  = {1'b0, r_len} + {17'd0, keep_bytes(bus.s_payload_tkeep)};
  assign w_len_next = w_len_sum[CTRL_LEN_W] ? LEN_MAX : w_len_sum[CTRL_LEN_W-1:0];

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_hdr_tready  = 1'b0;
    w_pay_tready  = 1'b0;
    w_ctrl_tvalid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_hdr_tready = 1'b1;
        if (bus.s_hdr_tvalid) w_next = w_hdr_ok ? ST_PAYLOAD : ST_DROP;
      end
      ST_PAYLOAD: begin
        w_pay_tready = w_slice_ready;
        if (w_fwd) begin
          if (bus.s_payload_tlast) w_next = r_hdr_last ? ST_CTRL : ST_IDLE;
          else if (w_beat_full)    w_next = ST_DROP;
        end
      end
      ST_DROP: begin
        w_pay_tready = 1'b1;
        if (bus.s_payload_tvalid && bus.s_payload_tlast)
          w_next = r_drop_to_ctrl ? ST_CTRL : ST_IDLE;
      end
      ST_CTRL: begin
        w_ctrl_tvalid = 1'b1;
        if (bus.m_ctrl_tready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_open         <= 1'b0;
      r_hdr_last     <= 1'b0;
      r_drop_to_ctrl <= 1'b0;
      r_addr         <= '0;
      r_len          <= '0;
      r_beat         <= '0;
      r_err          <= '0;
    end else begin
      r_err <= {w_overflow || w_short, w_hdr_acc && !w_hdr_ok};
      if (w_hdr_acc) begin
        r_beat         <= '0;
        r_hdr_last     <= w_hdr_last;
        r_drop_to_ctrl <= 1'b0;
        if (w_hdr_first && !r_open) begin
          r_open <= 1'b1;
          r_addr <= w_hdr_addr;
          r_len  <= '0;
        end
      end
      if (w_fwd) begin
        r_len  <= w_len_next;
        r_beat <= r_beat + 1'b1;
        // Only a cut-short final fragment still owes its control word after the drop.
        if (w_overflow) r_drop_to_ctrl <= r_hdr_last;
      end
      if ((r_state == ST_CTRL) && bus.m_ctrl_tready) r_open <= 1'b0;
    end
  end

  turf_axis_reg_slice #(.W(SLICE_W)) u_data_slice (
    .clk       (aclk),
    .rst       (areset),
    .i_s_data  ({w_out_last, bus.s_payload_tkeep, bus.s_payload_tdata}),
    .i_s_valid (w_fwd),
    .o_s_ready (w_slice_ready),
    .o_m_data  (w_slice_out),
    .o_m_valid (bus.m_data_tvalid),
    .i_m_ready (bus.m_data_tready)
  );

  assign bus.m_data_tdata     = w_slice_out[63:0];
  assign bus.m_data_tkeep     = w_slice_out[71:64];
  assign bus.m_data_tlast     = w_slice_out[72];
  assign bus.s_hdr_tready     = w_hdr_tready;
  assign bus.s_payload_tready = w_pay_tready;
  assign bus.m_ctrl_tvalid    = w_ctrl_tvalid;
  assign bus.m_ctrl_tdata     = pack_ctrl(r_addr, r_len);
  assign err_o                = r_err;
  assign dbg_state_o          = r_state;

endmodule

// File: tb/tb_turf_fragment_reassembler.sv
// Directed bench for turf_fragment_reassembler: fragment-level reference model, scoreboarded
// data/control streams, error pulse accounting and a few hand-computed expectations.
module tb_turf_fragment_reassembler;
  import turf_frag_pkg::*;

  logic       aclk = 1'b0;
  logic       areset = 1'b1;
  logic [9:0] nfc = 10'd17;
  logic [1:0] err_o;
  logic [1:0] dbg_state;

  turf_fragment_reassembler_if bus();

  turf_fragment_reassembler dut (
    .aclk              (aclk),
    .areset            (areset),
    .nfragment_count_i (nfc),
    .bus               (bus),
    .err_o             (err_o),
    .dbg_state_o       (dbg_state)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  logic [72:0] exp_q[$];
  logic [31:0] exp_ctrl_q[$];

  bit          m_open = 0;
  logic [11:0] m_addr = '0;
  logic [19:0] m_len = '0;
  int          m_err0 = 0;
  int          m_err1 = 0;

  int          seen_err0 = 0;
  int          seen_err1 = 0;
  int          beats_seen = 0;
  int          tlast_seen = 0;
  logic [7:0]  last_keep = '0;
  logic [31:0] last_ctrl = '0;
  bit          bp_en = 0;
  bit          ctrl_wait = 0;
  logic [31:0] ctrl_held = '0;

  logic [63:0] fd[64];
  logic [7:0]  fk[64];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Fragment-level reference: what the event stream must look like after this fragment.
  task automatic model_frag(input logic [11:0] a, input bit f, input bit l, input int n);
    int lim;
    int fw;
    int t;
    lim = int'(nfc) + 1;
    if (f && !m_open) begin
      m_open = 1;
      m_addr = a;
      m_len  = '0;
    end else if (!(!f && m_open && a == m_addr)) begin
      m_err0++;
      return;
    end
    fw = (n < lim) ? n : lim;
    for (int i = 0; i < fw; i++) begin
      exp_q.push_back({(l && i == fw - 1), fk[i], fd[i]});
      t = int'(m_len) + $countones(fk[i]);
      m_len = (t > 1048575) ? 20'hFFFFF : 20'(t);
    end
    if (n > lim || (!l && n != lim)) m_err1++;
    if (l) begin
      exp_ctrl_q.push_back({m_addr, m_len});
      m_open = 0;
    end
  endtask

  task automatic send_hdr(input logic [11:0] a, input bit f, input bit l);
    int n;
    bit hs;
    n  = 0;
    hs = 0;
    bus.s_hdr_tdata  = {2'b00, l, f, a};
    bus.s_hdr_tvalid = 1'b1;
    while (!hs && n < 1000) begin
      @(negedge aclk);
      hs = bus.s_hdr_tready;
      @(posedge aclk);
      n++;
    end
    #1 bus.s_hdr_tvalid = 1'b0;
    if (!hs) begin
      checks++;
      errors++;
      $display("FAIL hdr_timeout actual=no_tready expected=tready");
    end
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input bit last);
    int n;
    bit hs;
    n  = 0;
    hs = 0;
    bus.s_payload_tdata  = d;
    bus.s_payload_tkeep  = k;
    bus.s_payload_tlast  = last;
    bus.s_payload_tvalid = 1'b1;
    while (!hs && n < 1000) begin
      @(negedge aclk);
      hs = bus.s_payload_tready;
      @(posedge aclk);
      n++;
    end
    #1 bus.s_payload_tvalid = 1'b0;
    if (!hs) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout actual=no_tready expected=tready");
    end
  endtask

  task automatic frag(input logic [11:0] a, input bit f, input bit l, input int n,
                      input logic [7:0] last_keep_in);
    for (int i = 0; i < n; i++) begin
      fd[i] = {$urandom, $urandom};
      fk[i] = (i == n - 1) ? last_keep_in : 8'hFF;
    end
    model_frag(a, f, l, n);
    send_hdr(a, f, l);
    for (int i = 0; i < n; i++) send_beat(fd[i], fk[i], i == n - 1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_ctrl_q.size() != 0) && n < 5000) begin
      @(posedge aclk);
      n++;
    end
    repeat (4) @(posedge aclk);
    #1;
    if (n >= 5000) begin
      checks++;
      errors++;
      $display("FAIL %s_drain actual=%0d/%0d_left expected=0/0", name, exp_q.size(), exp_ctrl_q.size());
    end
    chk({name, "_err0"}, 80'(seen_err0), 80'(m_err0));
    chk({name, "_err1"}, 80'(seen_err1), 80'(m_err1));
  endtask

  task automatic full_event_1000();
    for (int k = 0; k < 7; k++) frag(12'h000, k == 0, k == 6, (k < 6) ? 18 : 17, 8'hFF);
  endtask

  // Downstream readiness: always ready, or 50% random backpressure.
  initial begin
    bus.m_data_tready = 1'b1;
    bus.m_ctrl_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      bus.m_data_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.m_ctrl_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Scoreboard: every transfer, mid-cycle, against the expected queues.
  initial begin
    logic [72:0] e;
    logic [31:0] ec;
    forever begin
      @(negedge aclk);
      if (areset) begin
        ctrl_wait = 0;
      end else begin
        if (ctrl_wait)
          chk("ctrl_hold", {47'd0, bus.m_ctrl_tvalid, bus.m_ctrl_tdata}, {47'd0, 1'b1, ctrl_held});
        ctrl_wait = bus.m_ctrl_tvalid && !bus.m_ctrl_tready;
        ctrl_held = bus.m_ctrl_tdata;
        if (bus.m_data_tvalid && bus.m_data_tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL data_extra actual=%h expected=none", bus.m_data_tdata);
          end else begin
            e = exp_q.pop_front();
            chk("data_beat", {7'd0, bus.m_data_tlast, bus.m_data_tkeep, bus.m_data_tdata}, {7'd0, e});
          end
          beats_seen++;
          if (bus.m_data_tlast) tlast_seen++;
          last_keep = bus.m_data_tkeep;
        end
        if (bus.m_ctrl_tvalid && bus.m_ctrl_tready) begin
          if (exp_ctrl_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL ctrl_extra actual=%h expected=none", bus.m_ctrl_tdata);
          end else begin
            ec = exp_ctrl_q.pop_front();
            chk("ctrl_word", {48'd0, bus.m_ctrl_tdata}, {48'd0, ec});
          end
          last_ctrl = bus.m_ctrl_tdata;
        end
        if (err_o[0]) seen_err0++;
        if (err_o[1]) seen_err1++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_hdr_tdata      = '0;
    bus.s_hdr_tvalid     = 1'b0;
    bus.s_payload_tdata  = '0;
    bus.s_payload_tkeep  = '0;
    bus.s_payload_tlast  = 1'b0;
    bus.s_payload_tvalid = 1'b0;

    #2;
    chk("rst_data_valid", 80'(bus.m_data_tvalid), 80'd0);
    chk("rst_ctrl_valid", 80'(bus.m_ctrl_tvalid), 80'd0);
    chk("rst_data", {7'd0, bus.m_data_tlast, bus.m_data_tkeep, bus.m_data_tdata}, 80'd0);
    chk("rst_ctrl_data", 80'(bus.m_ctrl_tdata), 80'd0);
    chk("rst_err", 80'(err_o), 80'd0);
    chk("rst_hdr_ready", 80'(bus.s_hdr_tready), 80'd1);
    chk("rst_pay_ready", 80'(bus.s_payload_tready), 80'd0);
    chk("rst_state", 80'(dbg_state), 80'd0);
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;

    // 1000-byte event in 7 fragments, no backpressure.
    beats_seen = 0;
    tlast_seen = 0;
    full_event_1000();
    drain("t1");
    chk("t1_beats", 80'(beats_seen), 80'd125);
    chk("t1_tlast_count", 80'(tlast_seen), 80'd1);
    chk("t1_ctrl_lit", 80'(last_ctrl), 80'h0000_03E8);
    chk("t1_no_err", 80'(seen_err0 + seen_err1), 80'd0);

    // Single-beat event with partial keep.
    beats_seen = 0;
    frag(12'hABC, 1, 1, 1, 8'h1F);
    drain("t2");
    chk("t2_beats", 80'(beats_seen), 80'd1);
    chk("t2_keep", 80'(last_keep), 80'h1F);
    chk("t2_ctrl_lit", 80'(last_ctrl), 80'hABC0_0005);

    // Continuation fragment with no open event, then a clean event.
    beats_seen = 0;
    frag(12'h123, 0, 0, 18, 8'hFF);
    frag(12'h124, 1, 1, 3, 8'h0F);
    drain("t3");
    chk("t3_beats", 80'(beats_seen), 80'd3);
    chk("t3_ctrl_lit", 80'(last_ctrl), 80'h1240_0014);
    chk("t3_err0_lit", 80'(seen_err0), 80'd1);

    // Oversized middle fragment is cut at 18 beats.
    beats_seen = 0;
    frag(12'h321, 1, 0, 18, 8'hFF);
    frag(12'h321, 0, 0, 20, 8'hFF);
    frag(12'h321, 0, 1, 5, 8'hFF);
    drain("t4");
    chk("t4_beats", 80'(beats_seen), 80'd41);
    chk("t4_ctrl_lit", 80'(last_ctrl), 80'h3210_0148);
    chk("t4_err1_lit", 80'(seen_err1), 80'd1);

    // Same 1000-byte event under random downstream backpressure.
    bp_en = 1;
    beats_seen = 0;
    tlast_seen = 0;
    full_event_1000();
    drain("t5");
    bp_en = 0;
    chk("t5_beats", 80'(beats_seen), 80'd125);
    chk("t5_tlast_count", 80'(tlast_seen), 80'd1);
    chk("t5_ctrl_lit", 80'(last_ctrl), 80'h0000_03E8);

    // Reset after three fragments of an open event; the partial event vanishes.
    for (int k = 0; k < 3; k++) frag(12'h055, k == 0, 0, 18, 8'hFF);
    areset = 1'b1;
    exp_q.delete();
    exp_ctrl_q.delete();
    m_open = 0;
    m_len  = '0;
    #1;
    chk("mid_rst_data_valid", 80'(bus.m_data_tvalid), 80'd0);
    chk("mid_rst_ctrl_valid", 80'(bus.m_ctrl_tvalid), 80'd0);
    chk("mid_rst_err", 80'(err_o), 80'd0);
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
    beats_seen = 0;
    frag(12'h2A0, 1, 0, 18, 8'hFF);
    frag(12'h2A0, 0, 1, 4, 8'h03);
    drain("t6");
    chk("t6_beats", 80'(beats_seen), 80'd22);
    chk("t6_ctrl_lit", 80'(last_ctrl), 80'h2A00_00AA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
